// File: rtl/gato_pkg.sv
// rtl/gato_pkg.sv - shared constants, FSM states and line table for the tic-tac-toe referee
//
// Purpose: cell codes, referee FSM state enum, the 8 winning lines as
// 0-based cell indices, and a helper to pull one cell out of a packed board.
package gato_pkg;

    localparam logic [1:0] VACIA  = 2'b00;
    localparam logic [1:0] COD_P1 = 2'b11;
    localparam logic [1:0] COD_P2 = 2'b01;

    localparam int NUM_CELDAS = 9;
    localparam int NUM_LINEAS = 8;

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        EVALUA = 2'd1,
        FIN    = 2'd2
    } estado_t;

    // Line l uses cells LINEAS[l][0..2]; cell index 0 is c1.
    localparam logic [3:0] LINEAS [NUM_LINEAS][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Cell k (0-based) of a packed board lives at bits [2k+1:2k].
    function automatic logic [1:0] celda(input logic [17:0] t, input logic [3:0] k);
        logic [17:0] s;
        s = t >> {k, 1'b0};
        return s[1:0];
    endfunction

endpackage

// File: rtl/detector_linea.sv
// rtl/detector_linea.sv - combinational three-in-a-row detector
//
// Purpose: scans the 8 lines of a packed board and reports the lowest-index
// line whose three cells hold the same non-empty code.
// Ports:
//   i_tablero      in  18  packed board, cell k (0-based) at [2k+1:2k]
//   o_hay_ganador  out 1   some line is complete
//   o_codigo       out 2   code occupying the winning line
//   o_linea        out 3   lowest winning line index
module detector_linea
    import gato_pkg::*;
(
    input  logic [17:0] i_tablero,
    output logic        o_hay_ganador,
    output logic [1:0]  o_codigo,
    output logic [2:0]  o_linea
);

    logic [1:0] w_a;
    logic [1:0] w_b;
    logic [1:0] w_c;

    // Scanning from the highest index down lets the lowest winning line
    // overwrite any higher one.
    always_comb begin
        o_hay_ganador = 1'b0;
        o_codigo      = VACIA;
        o_linea       = 3'd0;
        w_a           = VACIA;
        w_b           = VACIA;
        w_c           = VACIA;
        for (int l = NUM_LINEAS - 1; l >= 0; l--) begin
            w_a = celda(i_tablero, LINEAS[l][0]);
            w_b = celda(i_tablero, LINEAS[l][1]);
            w_c = celda(i_tablero, LINEAS[l][2]);
            if ((w_a != VACIA) && (w_a == w_b) && (w_b == w_c)) begin
                o_hay_ganador = 1'b1;
                o_codigo      = w_a;
                o_linea       = 3'(l);
            end
        end
    end

endmodule

// File: rtl/arbitro_gato.sv
// rtl/arbitro_gato.sv - tic-tac-toe referee: turn order, move validation, win/draw detection
//
// Purpose: synchronises the selector's board and move flags, accepts one
// legal mark at a time into a validated board, then evaluates win/draw.
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   guarda_c1..guarda_c9   2-bit cell codes from the selector (asynchronous)
//   p1_mm, p2_mm           player-moved flags (asynchronous)
//   reinicio               synchronous new-game request
//   turno_p1               1 = player 1 to move
//   tablero                validated board, cell k at [2k-1:2k-2]
//   movimientos            accepted moves 0..9
//   ganador, linea         winning code and lowest winning line index
//   empate, fin_juego      draw flag, game-over flag
//   ilegal                 one-cycle pulse on a rejected board change
module arbitro_gato
    import gato_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [1:0] COD_P1      = gato_pkg::COD_P1,
    parameter logic [1:0] COD_P2      = gato_pkg::COD_P2
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  guarda_c1,
    input  logic [1:0]  guarda_c2,
    input  logic [1:0]  guarda_c3,
    input  logic [1:0]  guarda_c4,
    input  logic [1:0]  guarda_c5,
    input  logic [1:0]  guarda_c6,
    input  logic [1:0]  guarda_c7,
    input  logic [1:0]  guarda_c8,
    input  logic [1:0]  guarda_c9,
    input  logic        p1_mm,
    input  logic        p2_mm,
    input  logic        reinicio,
    output logic        turno_p1,
    output logic [17:0] tablero,
    output logic [3:0]  movimientos,
    output logic [1:0]  ganador,
    output logic        empate,
    output logic        fin_juego,
    output logic [2:0]  linea,
    output logic        ilegal
);

    logic [SYNC_STAGES-1:0][17:0] r_sync_b;
    logic [SYNC_STAGES-1:0]       r_sync_p1;
    logic [SYNC_STAGES-1:0]       r_sync_p2;
    logic [17:0]                  r_snap;
    estado_t                      r_estado;
    logic [17:0]                  r_tablero;
    logic [3:0]                   r_mov;
    logic                         r_turno;
    logic [1:0]                   r_gan;
    logic                         r_emp;
    logic                         r_fin;
    logic [2:0]                   r_lin;
    logic                         r_ilegal;

    logic [17:0] w_board_in;
    logic [17:0] w_board_s;
    logic        w_p1_s;
    logic        w_p2_s;
    logic        w_cambio;
    logic [3:0]  w_cnt_nuevo;
    logic [3:0]  w_idx_nuevo;
    logic [1:0]  w_cod_nuevo;
    logic        w_sobrescribe;
    logic [1:0]  w_turno_cod;
    logic        w_flags_ok;
    logic        w_legal;
    logic        w_hay_ganador;
    logic [1:0]  w_cod_ganador;
    logic [2:0]  w_lin_ganador;

    estado_t     w_estado_d;
    logic [17:0] w_snap_d;
    logic [17:0] w_tablero_d;
    logic [3:0]  w_mov_d;
    logic        w_turno_d;
    logic [1:0]  w_gan_d;
    logic        w_emp_d;
    logic        w_fin_d;
    logic [2:0]  w_lin_d;
    logic        w_ilegal_d;

    assign w_board_in = {guarda_c9, guarda_c8, guarda_c7, guarda_c6, guarda_c5,
                         guarda_c4, guarda_c3, guarda_c2, guarda_c1};
    assign w_board_s  = r_sync_b[SYNC_STAGES-1];
    assign w_p1_s     = r_sync_p1[SYNC_STAGES-1];
    assign w_p2_s     = r_sync_p2[SYNC_STAGES-1];
    assign w_cambio   = (w_board_s != r_snap);

    // Classify the synced board against the validated one: newly filled
    // cells (empty here, non-empty there) and tampering with occupied cells.
    always_comb begin
        w_cnt_nuevo   = 4'd0;
        w_idx_nuevo   = 4'd0;
        w_cod_nuevo   = VACIA;
        w_sobrescribe = 1'b0;
        for (int i = 0; i < NUM_CELDAS; i++) begin
            if (celda(r_tablero, 4'(i)) == VACIA) begin
                if (celda(w_board_s, 4'(i)) != VACIA) begin
                    w_cnt_nuevo = w_cnt_nuevo + 4'd1;
                    w_idx_nuevo = 4'(i);
                    w_cod_nuevo = celda(w_board_s, 4'(i));
                end
            end else if (celda(w_board_s, 4'(i)) != celda(r_tablero, 4'(i))) begin
                w_sobrescribe = 1'b1;
            end
        end
    end

    assign w_turno_cod = r_turno ? COD_P1 : COD_P2;
    assign w_flags_ok  = (w_p1_s == r_turno) && (w_p2_s == !r_turno);
    assign w_legal     = (w_cnt_nuevo == 4'd1) && (w_cod_nuevo == w_turno_cod) &&
                         !w_sobrescribe && w_flags_ok;

    detector_linea u_detector (
        .i_tablero     (r_tablero),
        .o_hay_ganador (w_hay_ganador),
        .o_codigo      (w_cod_ganador),
        .o_linea       (w_lin_ganador)
    );

    always_comb begin
        w_estado_d  = r_estado;
        w_snap_d    = w_board_s;
        w_tablero_d = r_tablero;
        w_mov_d     = r_mov;
        w_turno_d   = r_turno;
        w_gan_d     = r_gan;
        w_emp_d     = r_emp;
        w_fin_d     = r_fin;
        w_lin_d     = r_lin;
        w_ilegal_d  = 1'b0;
        case (r_estado)
            ESPERA: begin
                if (w_cambio) begin
                    if (w_legal) begin
                        for (int i = 0; i < NUM_CELDAS; i++) begin
                            if (4'(i) == w_idx_nuevo) begin
                                w_tablero_d[2*i +: 2] = w_cod_nuevo;
                            end
                        end
                        w_mov_d    = (r_mov < 4'd9) ? (r_mov + 4'd1) : r_mov;
                        w_estado_d = EVALUA;
                    end else begin
                        w_ilegal_d = 1'b1;
                    end
                end
            end
            EVALUA: begin
                // Freezing the snapshot here makes a change that lands during
                // evaluation still look like a change in the following ESPERA.
                w_snap_d = r_snap;
                if (w_hay_ganador) begin
                    w_gan_d    = w_cod_ganador;
                    w_lin_d    = w_lin_ganador;
                    w_fin_d    = 1'b1;
                    w_estado_d = FIN;
                end else if (r_mov == 4'd9) begin
                    w_emp_d    = 1'b1;
                    w_fin_d    = 1'b1;
                    w_estado_d = FIN;
                end else begin
                    w_turno_d  = !r_turno;
                    w_estado_d = ESPERA;
                end
            end
            FIN: begin
                if (w_cambio) begin
                    w_ilegal_d = 1'b1;
                end
            end
            default: begin
                w_estado_d = ESPERA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || reinicio) begin
            r_sync_b  <= '0;
            r_sync_p1 <= '0;
            r_sync_p2 <= '0;
            r_snap    <= '0;
            r_estado  <= ESPERA;
            r_tablero <= '0;
            r_mov     <= 4'd0;
            r_turno   <= 1'b1;
            r_gan     <= VACIA;
            r_emp     <= 1'b0;
            r_fin     <= 1'b0;
            r_lin     <= 3'd0;
            r_ilegal  <= 1'b0;
        end else begin
            r_sync_b  <= {r_sync_b[SYNC_STAGES-2:0], w_board_in};
            r_sync_p1 <= {r_sync_p1[SYNC_STAGES-2:0], p1_mm};
            r_sync_p2 <= {r_sync_p2[SYNC_STAGES-2:0], p2_mm};
            r_snap    <= w_snap_d;
            r_estado  <= w_estado_d;
            r_tablero <= w_tablero_d;
            r_mov     <= w_mov_d;
            r_turno   <= w_turno_d;
            r_gan     <= w_gan_d;
            r_emp     <= w_emp_d;
            r_fin     <= w_fin_d;
            r_lin     <= w_lin_d;
            r_ilegal  <= w_ilegal_d;
        end
    end

    assign turno_p1    = r_turno;
    assign tablero     = r_tablero;
    assign movimientos = r_mov;
    assign ganador     = r_gan;
    assign empate      = r_emp;
    assign fin_juego   = r_fin;
    assign linea       = r_lin;
    assign ilegal      = r_ilegal;

endmodule

// File: tb/tb_arbitro_gato.sv
// tb/tb_arbitro_gato.sv - self-checking bench for arbitro_gato
module tb_arbitro_gato;

    localparam int         SYNC = 2;
    localparam logic [1:0] P1   = 2'b11;
    localparam logic [1:0] P2   = 2'b01;

    logic        clk = 1'b0;
    logic        reset;
    logic        reinicio;
    logic        p1_mm;
    logic        p2_mm;
    logic [17:0] in_board;
    logic        turno_p1;
    logic [17:0] tablero;
    logic [3:0]  movimientos;
    logic [1:0]  ganador;
    logic        empate;
    logic        fin_juego;
    logic [2:0]  linea;
    logic        ilegal;

    int n_chk = 0;
    int n_ok  = 0;

    always #5 clk = ~clk;

    arbitro_gato #(.SYNC_STAGES(SYNC), .COD_P1(P1), .COD_P2(P2)) dut (
        .clk         (clk),
        .reset       (reset),
        .guarda_c1   (in_board[1:0]),
        .guarda_c2   (in_board[3:2]),
        .guarda_c3   (in_board[5:4]),
        .guarda_c4   (in_board[7:6]),
        .guarda_c5   (in_board[9:8]),
        .guarda_c6   (in_board[11:10]),
        .guarda_c7   (in_board[13:12]),
        .guarda_c8   (in_board[15:14]),
        .guarda_c9   (in_board[17:16]),
        .p1_mm       (p1_mm),
        .p2_mm       (p2_mm),
        .reinicio    (reinicio),
        .turno_p1    (turno_p1),
        .tablero     (tablero),
        .movimientos (movimientos),
        .ganador     (ganador),
        .empate      (empate),
        .fin_juego   (fin_juego),
        .linea       (linea),
        .ilegal      (ilegal)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic [17:0] c(input int k, input logic [1:0] v);
        logic [17:0] t;
        t = 18'(v);
        return t << (2 * (k - 1));
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rein;
        logic [17:0] board;
        bit          f1;
        bit          f2;
        int          ile;
        logic [17:0] tab;
        int          mov;
        bit          tur;
        logic [1:0]  gan;
        bit          emp;
        bit          fin;
        int          lin;
    } vec_t;

    vec_t tabla[$];

    function automatic void add(input bit rein, input logic [17:0] board, input bit f1, input bit f2,
                                input int ile, input logic [17:0] tab, input int mov, input bit tur,
                                input logic [1:0] gan, input bit emp, input bit fin, input int lin);
        vec_t v;
        v.rein = rein; v.board = board; v.f1 = f1; v.f2 = f2; v.ile = ile; v.tab = tab;
        v.mov = mov; v.tur = tur; v.gan = gan; v.emp = emp; v.fin = fin; v.lin = lin;
        tabla.push_back(v);
    endfunction

    // A legal alternating game starting with P1; only the last move may end it.
    function automatic void add_seq(input int cs[9], input int n, input logic [1:0] gan_f,
                                    input bit emp_f, input int lin_f);
        logic [17:0] d;
        bit p1t, last, ends;
        d = '0;
        for (int i = 0; i < n; i++) begin
            p1t  = (i % 2 == 0);
            last = (i == n - 1);
            ends = last && ((gan_f != 2'b00) || emp_f);
            d    = d | c(cs[i], p1t ? P1 : P2);
            add(i == 0, d, p1t, !p1t, 0, d, i + 1, ends ? p1t : !p1t,
                last ? gan_f : 2'b00, last && emp_f, ends, last ? lin_f : 0);
        end
    endfunction

    // ---------------- reference model ----------------
    int LIN[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int m_tab[9];
    int m_prev[9];
    bit m_turn;
    int m_mov;
    int m_gan;
    bit m_emp;
    bit m_fin;
    int m_lin;

    function automatic void m_reset();
        for (int k = 0; k < 9; k++) begin m_tab[k] = 0; m_prev[k] = 0; end
        m_turn = 1; m_mov = 0; m_gan = 0; m_emp = 0; m_fin = 0; m_lin = 0;
    endfunction

    function automatic logic [17:0] m_board();
        logic [17:0] b;
        b = '0;
        for (int k = 0; k < 9; k++) b = b | (18'(m_tab[k]) << (2 * k));
        return b;
    endfunction

    // Returns how many ilegal pulses the referee should produce for this input.
    function automatic int m_step(input logic [17:0] b, input bit f1, input bit f2);
        int nb[9];
        int nnew, inew, want;
        bit changed, over;
        changed = 0; over = 0; nnew = 0; inew = 0;
        for (int k = 0; k < 9; k++) begin
            nb[k] = int'(b[2*k +: 2]);
            if (nb[k] != m_prev[k]) changed = 1;
            m_prev[k] = nb[k];
        end
        if (!changed) return 0;
        if (m_fin) return 1;
        for (int k = 0; k < 9; k++) begin
            if (m_tab[k] == 0 && nb[k] != 0) begin nnew++; inew = k; end
            else if (m_tab[k] != 0 && nb[k] != m_tab[k]) over = 1;
        end
        want = m_turn ? int'(P1) : int'(P2);
        if (nnew != 1 || nb[inew] != want || over || f1 != m_turn || f2 == m_turn) return 1;
        m_tab[inew] = want;
        m_mov++;
        for (int l = 0; l < 8; l++) begin
            if (!m_fin && m_tab[LIN[l][0]] != 0 && m_tab[LIN[l][0]] == m_tab[LIN[l][1]]
                && m_tab[LIN[l][1]] == m_tab[LIN[l][2]]) begin
                m_gan = m_tab[LIN[l][0]]; m_lin = l; m_fin = 1;
            end
        end
        if (!m_fin) begin
            if (m_mov == 9) begin m_emp = 1; m_fin = 1; end
            else m_turn = !m_turn;
        end
        return 0;
    endfunction

    // ---------------- drivers ----------------
    task automatic aplicar(input logic [17:0] b, input bit f1, input bit f2, output int pulses);
        @(negedge clk);
        in_board = b; p1_mm = f1; p2_mm = f2;
        pulses = 0;
        repeat (SYNC + 4) begin
            @(posedge clk); #1;
            if (ilegal) pulses++;
        end
    endtask

    task automatic reiniciar();
        @(negedge clk);
        reinicio = 1; in_board = '0; p1_mm = 0; p2_mm = 0;
        @(negedge clk);
        reinicio = 0;
        repeat (SYNC + 2) @(negedge clk);
    endtask

    task automatic paso_aleatorio(output logic [17:0] b, output bit f1, output bit f2);
        int empt[$];
        int occ[$];
        int r, k, k2;
        logic [1:0] me, other;
        for (int i = 0; i < 9; i++) if (m_tab[i] == 0) empt.push_back(i); else occ.push_back(i);
        me = m_turn ? P1 : P2;
        other = m_turn ? P2 : P1;
        b = m_board(); f1 = m_turn; f2 = !m_turn;
        r = $urandom_range(0, 9);
        if (r == 7 && occ.size() > 0) begin
            k = occ[$urandom_range(0, occ.size() - 1)];
            b[2*k +: 2] = (m_tab[k] == int'(P1)) ? P2 : P1;
        end else if (empt.size() > 0) begin
            k = empt[$urandom_range(0, empt.size() - 1)];
            b[2*k +: 2] = (r == 6) ? other : me;
            if (r == 8 && empt.size() > 1) begin
                k2 = k;
                while (k2 == k) k2 = empt[$urandom_range(0, empt.size() - 1)];
                b[2*k2 +: 2] = me;
            end
            if (r == 9) begin f1 = !m_turn; f2 = m_turn; end
        end
    endtask

    initial begin
        int pulses, expp, tras_fin;
        logic [17:0] b, bA5;
        bit f1, f2;
        vec_t v;

        reset = 1; reinicio = 0; in_board = '0; p1_mm = 0; p2_mm = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 0;
        @(posedge clk); #1;

        // reset values
        chk("rst_tablero", int'(tablero), 0);
        chk("rst_mov", int'(movimientos), 0);
        chk("rst_turno", int'(turno_p1), 1);
        chk("rst_ganador", int'(ganador), 0);
        chk("rst_empate", int'(empate), 0);
        chk("rst_fin", int'(fin_juego), 0);
        chk("rst_linea", int'(linea), 0);
        chk("rst_ilegal", int'(ilegal), 0);

        // latency: c5 = P1 visible after SYNC+1 edges, turn flips one edge later
        @(negedge clk); in_board = c(5, P1); p1_mm = 1; p2_mm = 0;
        repeat (SYNC) @(posedge clk); #1;
        chk("lat_tab_early", int'(tablero), 0);
        @(posedge clk); #1;
        chk("lat_tab_c5", int'(tablero[9:8]), int'(P1));
        chk("lat_turno_hold", int'(turno_p1), 1);
        @(posedge clk); #1;
        chk("lat_turno", int'(turno_p1), 0);
        chk("lat_mov", int'(movimientos), 1);

        // directed table
        add_seq('{1,4,2,5,3,0,0,0,0}, 5, P1, 0, 0);
        bA5 = c(1,P1) | c(4,P2) | c(2,P1) | c(5,P2) | c(3,P1);
        add(0, bA5 | c(6,P2), 0, 1, 1, bA5, 5, 1, P1, 0, 1, 0);
        add_seq('{1,2,3,5,4,6,8,7,9}, 9, 2'b00, 1, 0);
        add_seq('{1,2,3,5,4,6,8,9,7}, 9, P1, 0, 3);
        add_seq('{1,3,2,5,9,7,0,0,0}, 6, P2, 0, 7);
        add(1, c(5,P1), 1, 0, 0, c(5,P1), 1, 0, 2'b00, 0, 0, 0);
        add(0, c(5,P2), 0, 1, 1, c(5,P1), 1, 0, 2'b00, 0, 0, 0);
        add(0, c(5,P1), 0, 1, 1, c(5,P1), 1, 0, 2'b00, 0, 0, 0);
        add(1, c(1,P2), 0, 1, 1, 18'd0, 0, 1, 2'b00, 0, 0, 0);
        add(0, c(2,P1) | c(3,P1), 1, 0, 1, 18'd0, 0, 1, 2'b00, 0, 0, 0);
        add(0, c(2,P1), 1, 0, 0, c(2,P1), 1, 0, 2'b00, 0, 0, 0);
        add(0, c(2,P1) | c(7,P2), 1, 0, 1, c(2,P1), 1, 0, 2'b00, 0, 0, 0);
        add(0, c(2,P1) | c(7,P2), 0, 1, 0, c(2,P1), 1, 0, 2'b00, 0, 0, 0);

        foreach (tabla[i]) begin
            v = tabla[i];
            if (v.rein) reiniciar();
            aplicar(v.board, v.f1, v.f2, pulses);
            chk($sformatf("vec%0d_ilegal", i), pulses, v.ile);
            chk($sformatf("vec%0d_tablero", i), int'(tablero), int'(v.tab));
            chk($sformatf("vec%0d_mov", i), int'(movimientos), v.mov);
            chk($sformatf("vec%0d_turno", i), int'(turno_p1), int'(v.tur));
            chk($sformatf("vec%0d_ganador", i), int'(ganador), int'(v.gan));
            chk($sformatf("vec%0d_empate", i), int'(empate), int'(v.emp));
            chk($sformatf("vec%0d_fin", i), int'(fin_juego), int'(v.fin));
            if (v.gan != 2'b00) chk($sformatf("vec%0d_linea", i), int'(linea), v.lin);
        end

        // reinicio while the winning move is being evaluated
        reiniciar();
        aplicar(c(1,P1), 1, 0, pulses);
        aplicar(c(1,P1) | c(4,P2), 0, 1, pulses);
        aplicar(c(1,P1) | c(4,P2) | c(2,P1), 1, 0, pulses);
        aplicar(c(1,P1) | c(4,P2) | c(2,P1) | c(5,P2), 0, 1, pulses);
        @(negedge clk); in_board = bA5; p1_mm = 1; p2_mm = 0;
        repeat (SYNC + 1) @(posedge clk); #1;
        chk("evrein_mov5", int'(movimientos), 5);
        reinicio = 1; in_board = '0; p1_mm = 0; p2_mm = 0;
        @(posedge clk); #1;
        reinicio = 0;
        chk("evrein_tablero", int'(tablero), 0);
        chk("evrein_mov", int'(movimientos), 0);
        chk("evrein_turno", int'(turno_p1), 1);
        chk("evrein_ganador", int'(ganador), 0);
        chk("evrein_fin", int'(fin_juego), 0);
        chk("evrein_linea", int'(linea), 0);
        chk("evrein_ilegal", int'(ilegal), 0);
        repeat (SYNC + 3) @(posedge clk); #1;
        chk("evrein_ganador_late", int'(ganador), 0);

        // randomized games against the model
        for (int g = 0; g < 8; g++) begin
            reiniciar();
            m_reset();
            tras_fin = 0;
            for (int s = 0; s < 16 && tras_fin < 3; s++) begin
                paso_aleatorio(b, f1, f2);
                expp = m_step(b, f1, f2);
                aplicar(b, f1, f2, pulses);
                chk($sformatf("g%0d_s%0d_ilegal", g, s), pulses, expp);
                chk($sformatf("g%0d_s%0d_tablero", g, s), int'(tablero), int'(m_board()));
                chk($sformatf("g%0d_s%0d_mov", g, s), int'(movimientos), m_mov);
                chk($sformatf("g%0d_s%0d_turno", g, s), int'(turno_p1), int'(m_turn));
                chk($sformatf("g%0d_s%0d_ganador", g, s), int'(ganador), m_gan);
                chk($sformatf("g%0d_s%0d_empate", g, s), int'(empate), int'(m_emp));
                chk($sformatf("g%0d_s%0d_fin", g, s), int'(fin_juego), int'(m_fin));
                if (m_gan != 0) chk($sformatf("g%0d_s%0d_linea", g, s), int'(linea), m_lin);
                if (m_fin) tras_fin++;
            end
        end

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
